rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-to-1 single-bit mux datapath among four requesters. It samples a 4-bit request vector and issues a registered one-hot grant. It drives the mux selects (s1, s0) to the granted source and returns the selected data bit as a registered, qualified output. A requester may hold the path for a bounded number of cycles before a waiting requester is forced in.

---
 rtl/rr_mux_arbiter.sv | 150 +++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_arbiter
//  Brief    : Round-robin arbiter sharing a 4:1 single-bit mux among four
//             requesters. Registered one-hot grant, registered mux selects,
//             registered qualified data output, bounded hold per owner.
//  Revision : 1.0  initial release
// ============================================================================
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 4  // 1..15 consecutive grant cycles while others wait
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       out,
  output logic       out_valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       out_q, out_d;
  logic       out_valid_q, out_valid_d;

  logic [3:0] others;
  logic [3:0] data_vec;
  logic [1:0] winner;
  logic       take;

  // First set bit of v scanning p, p+1, p+2, p+3 (mod 4); returns p when v is empty.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (v[idx]) rr_pick = idx;
    end
  endfunction

  assign data_vec = {d3, d2, d1, d0};
  assign others   = req & ~(4'b0001 << owner_q);

  // Next-state: arbitration decision, then a single shared "take new owner" update.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    winner     = 2'd0;
    take       = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          winner = rr_pick(req, ptr_q);
          take   = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          if (|others) begin
            // ptr already sits at owner+1, so no idle gap on handover
            winner = rr_pick(others, ptr_q);
            take   = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            hold_cnt_d = 4'd0;
          end
        end else if ((hold_cnt_q == c_max_hold) && (|others)) begin
          winner = rr_pick(others, ptr_q);
          take   = 1'b1;
        end else if (hold_cnt_q != c_max_hold) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase

    if (take) begin
      state_d    = GRANT;
      owner_d    = winner;
      sel_d      = winner;
      gnt_d      = 4'b0001 << winner;
      hold_cnt_d = 4'd1;
      ptr_d      = winner + 2'd1;
    end
  end

  // Datapath: capture the selected bit only while a grant is registered.
  always_comb begin
    out_d       = out_q;
    out_valid_d = |gnt_q;
    if (|gnt_q) out_d = data_vec[sel_q];
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= 4'd0;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'd0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_mux_arbiter
//  Brief    : Self-checking bench for rr_mux_arbiter with a behavioural
//             round-robin reference model and randomized requests.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_mux_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic [3:0] gnt;
  logic       s1, s0, out, out_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner as an integer (-1 = nobody), plain counters.
  int         m_owner;
  int         m_ptr;
  int         m_held;
  logic [1:0] m_sel;
  logic       m_out;
  logic       m_valid;
  int         wait_cnt [4];

  rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .s1(s1), .s0(s0), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 2'd0; m_out = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w; m_sel = 2'(w); m_held = 1; m_ptr = (w + 1) % 4;
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_edge();
    logic [3:0] dv;
    logic [3:0] oth;
    int w;
    dv = {d3, d2, d1, d0};
    if (m_owner >= 0) begin
      m_out = dv[m_sel]; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    oth = (m_owner >= 0) ? (req & ~(4'b0001 << m_owner)) : req;
    if (m_owner < 0) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) model_grant(w);
    end else if (!req[m_owner]) begin
      w = rr_pick(oth, m_ptr);
      if (w >= 0) model_grant(w);
      else begin m_owner = -1; m_held = 0; end
    end else if (m_held >= MAX_HOLD && oth != 4'b0000) begin
      model_grant(rr_pick(oth, m_ptr));
    end else begin
      m_held = (m_held + 1 > MAX_HOLD) ? MAX_HOLD : m_held + 1;
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_g;
    exp_g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("gnt", gnt, exp_g);
    chk("sel", {s1, s0}, m_sel);
    chk("out", out, m_out);
    chk("out_valid", out_valid, m_valid);
    chk("onehot", ($countones(gnt) <= 1), 1);
    if (gnt != 4'b0000) chk("gnt_vs_sel", gnt, 4'b0001 << {s1, s0});
    for (int i = 0; i < 4; i++) begin
      if (req[i] && !gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > 3 * MAX_HOLD + 1) begin
        chk("starve", wait_cnt[i], 3 * MAX_HOLD + 1);
        wait_cnt[i] = 0;
      end
    end
  endtask

  // Inputs change only at the falling edge; model runs on the rising edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    model_reset();
    tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset then single request from requester 0.
    do_reset();
    d0 = 1'b1; req = 4'b0001;
    tick();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_sel", {s1, s0}, 2'b00);
    tick();
    chk("t1_out", out, 1);
    chk("t1_valid", out_valid, 1);

    // All requesting: rotation every MAX_HOLD cycles starting at 0.
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      {d3, d2, d1, d0} = 4'($urandom);
      tick();
      chk("rot_gnt", gnt, 4'b0001 << ((c / MAX_HOLD) % 4));
    end

    // Lone requester keeps the path; then release.
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      {d3, d2, d1, d0} = 4'($urandom);
      tick();
      chk("solo_gnt", gnt, 4'b0100);
    end
    req = 4'b0000;
    tick();
    chk("rel_gnt", gnt, 4'b0000);
    chk("rel_valid_last", out_valid, 1);
    tick();
    chk("rel_valid", out_valid, 0);

    // Owner 1 drops while 0 and 3 request: ptr=2 so 3 wins, then 0.
    do_reset();
    req = 4'b0010;
    tick();
    chk("ho_gnt1", gnt, 4'b0010);
    req = 4'b1001;
    tick();
    chk("ho_gnt3", gnt, 4'b1000);
    chk("ho_valid", out_valid, 1);
    for (int c = 0; c < MAX_HOLD - 1; c++) tick();
    tick();
    chk("ho_gnt0", gnt, 4'b0001);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'b0100; d2 = 1'b1;
    tick();
    tick();
    chk("ar_pre_gnt", gnt, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", gnt, 4'b0000);
    chk("ar_sel", {s1, s0}, 2'b00);
    chk("ar_out", out, 0);
    chk("ar_valid", out_valid, 0);
    model_reset();
    req = 4'b0110;
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_first_gnt", gnt, 4'b0010);

    // Random requests with persistence so holds and rotations occur.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      {d3, d2, d1, d0} = 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
